// File: rtl/uvmt_cv32e40s_rvfi_cov_pkg.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40s_rvfi_cov_pkg
// Shared types and constants for the RVFI retirement coverage tracker.
//   seq_state_e : sequence detector state (IDLE, ARMED)
//   CLS_*       : bit positions of the event classes in class_i
// ----------------------------------------------------------------------------
package uvmt_cv32e40s_rvfi_cov_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1
    } seq_state_e;

    localparam int CLS_SPLIT_DATA    = 0;
    localparam int CLS_PUSHPOP       = 1;
    localparam int CLS_TABLEJUMP     = 2;
    localparam int CLS_TABLEJUMP_EXC = 3;

endpackage

// File: rtl/uvmt_cv32e40s_sat_counter.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40s_sat_counter
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : increment request for this cycle
//   cnt_o  : registered count
// ----------------------------------------------------------------------------
module uvmt_cv32e40s_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= sat_inc(cnt_o);
        end
    end

endmodule

// File: rtl/uvmt_cv32e40s_rvfi_seq_cov.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40s_rvfi_seq_cov
// RVFI coverage tracker: per-class saturating hit counters with sticky goal
// flags, a history of qualified class vectors, and a windowed SEQ_A -> SEQ_B
// sequence detector.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   rvfi_valid_i    : one retirement this cycle
//   rvfi_trap_i     : the retirement trapped
//   class_i         : class flags of the retirement
//   cnt_o           : per-class hit counters, class k at [k*CNT_W +: CNT_W]
//   covered_o       : sticky, counter k has reached GOAL
//   hist_o          : last DEPTH qualified vectors, entry 0 newest (low bits)
//   seq_state_o     : detector state (0 IDLE, 1 ARMED)
//   seq_hit_o       : one-cycle pulse when the sequence completes
//   seq_cnt_o       : saturating count of sequence hits
// ----------------------------------------------------------------------------
module uvmt_cv32e40s_rvfi_seq_cov
    import uvmt_cv32e40s_rvfi_cov_pkg::*;
#(
    parameter int NUM_CLASSES   = 4,
    parameter int CNT_W         = 8,
    parameter int GOAL          = 4,
    parameter int COUNT_TRAPPED = 0,
    parameter int DEPTH         = 4,
    parameter int SEQ_A         = 2,
    parameter int SEQ_B         = 0,
    parameter int WINDOW        = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rvfi_valid_i,
    input  logic                         rvfi_trap_i,
    input  logic [NUM_CLASSES-1:0]       class_i,
    output logic [NUM_CLASSES*CNT_W-1:0] cnt_o,
    output logic [NUM_CLASSES-1:0]       covered_o,
    output logic [DEPTH*NUM_CLASSES-1:0] hist_o,
    output logic [1:0]                   seq_state_o,
    output logic                         seq_hit_o,
    output logic [CNT_W-1:0]             seq_cnt_o
);

    localparam int               WIN_W   = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] GOAL_M1 = CNT_W'(GOAL - 1);

    // Stage p0: qualify the incoming retirement
    logic [NUM_CLASSES-1:0] q_p0;
    logic [NUM_CLASSES-1:0] inc_p0;
    logic                   a_p0;
    logic                   b_p0;

    assign q_p0   = (rvfi_trap_i && (COUNT_TRAPPED == 0)) ? '0 : class_i;
    assign inc_p0 = rvfi_valid_i ? q_p0 : '0;
    assign a_p0   = q_p0[SEQ_A];
    assign b_p0   = q_p0[SEQ_B];

    // Stage p1: registered counters, goal flags and history
    logic [NUM_CLASSES-1:0] covered_d;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
        uvmt_cv32e40s_sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (inc_p0[k]),
            .cnt_o  (cnt_o[k*CNT_W +: CNT_W])
        );
        // Counter moves by at most one, so next >= GOAL is current >= GOAL-1
        // with an increment; a saturated counter is already past GOAL.
        assign covered_d[k] = covered_o[k] |
                              (inc_p0[k] && (cnt_o[k*CNT_W +: CNT_W] >= GOAL_M1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            covered_o <= '0;
        end else begin
            covered_o <= covered_d;
        end
    end

    logic [DEPTH*NUM_CLASSES-1:0] hist_d;

    if (DEPTH == 1) begin : g_hist_one
        assign hist_d = q_p0;
    end else begin : g_hist_shift
        assign hist_d = {hist_o[(DEPTH-1)*NUM_CLASSES-1:0], q_p0};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_o <= '0;
        end else if (rvfi_valid_i) begin
            hist_o <= hist_d;
        end
    end

    // Stage p1: sequence detector
    seq_state_e       state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             hit_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            win_q     <= '0;
            seq_hit_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            seq_hit_o <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hit_d   = 1'b0;
        if (rvfi_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    // An arming retirement never completes its own arm.
                    if (a_p0) begin
                        state_d = ARMED;
                        win_d   = WIN_W'(WINDOW);
                    end
                end
                ARMED: begin
                    // Traps abort the pending sequence even when they count.
                    if (rvfi_trap_i) begin
                        state_d = IDLE;
                        win_d   = '0;
                    end else if (b_p0) begin
                        hit_d = 1'b1;
                        if (a_p0) begin
                            win_d = WIN_W'(WINDOW);
                        end else begin
                            state_d = IDLE;
                            win_d   = '0;
                        end
                    end else if (a_p0) begin
                        win_d = WIN_W'(WINDOW);
                    end else if (win_q == WIN_W'(1)) begin
                        state_d = IDLE;
                        win_d   = '0;
                    end else begin
                        win_d = win_q - WIN_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    win_d   = '0;
                end
            endcase
        end
    end

    assign seq_state_o = state_q;

    uvmt_cv32e40s_sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (hit_d),
        .cnt_o  (seq_cnt_o)
    );

endmodule
